// File: rtl/conv2_psum_accum_pkg.sv
// conv2_pkg: shared sizes, FSM state encoding and lane-slice helpers
// for the conv-layer-2 PE column and its partial-sum accumulator.
package conv2_pkg;

  localparam int unsigned LANES  = 12;
  localparam int unsigned PSUM_W = 20;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned OUT_W  = 8;

  localparam int unsigned PSUM_BUS_W = LANES * PSUM_W;
  localparam int unsigned OUT_BUS_W  = LANES * OUT_W;

  // Legacy state encodings, kept so existing netlists/debug scripts still decode
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    ACC  = ST_ACC
  } conv2_state_e;

  // Lane 0 occupies the most significant slice of each bus
  function automatic int unsigned psum_lsb(input int unsigned k);
    return (LANES - 1 - k) * PSUM_W;
  endfunction

  function automatic int unsigned out_lsb(input int unsigned k);
    return (LANES - 1 - k) * OUT_W;
  endfunction

endpackage

// File: rtl/conv2_psum_accum_if.sv
// conv2_psum_accum_if: column partial-sum input and requantised
// output-feature-map handshake of the conv2 accumulator.
interface conv2_psum_accum_if;
  import conv2_pkg::*;

  logic                  psum_vld;
  logic                  psum_first;
  logic                  psum_last;
  logic [PSUM_BUS_W-1:0] psum_in;
  logic                  psum_rdy;
  logic [3:0]            shift;
  logic                  out_vld;
  logic                  out_rdy;
  logic [OUT_BUS_W-1:0]  out_data;
  logic                  err;

  // Producer of partial sums / consumer of output words
  modport master (
    output psum_vld, psum_first, psum_last, psum_in, shift, out_rdy,
    input  psum_rdy, out_vld, out_data, err
  );

  // Accumulator side
  modport slave (
    input  psum_vld, psum_first, psum_last, psum_in, shift, out_rdy,
    output psum_rdy, out_vld, out_data, err
  );

endinterface

// File: rtl/conv2_psum_accum_requant_lane.sv
// conv2_requant_lane: combinational per-lane requantisation
// (optional round half up, arithmetic shift, ReLU, unsigned 8-bit clamp).
// Optional feature: CONV2_PSUM_ROUND_EN enables rounding before the shift.
module conv2_requant_lane
  import conv2_pkg::*;
(
  input  logic [ACC_W-1:0] acc_in,
  input  logic [3:0]       shift,
  output logic [OUT_W-1:0] q
);

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] shifted;

`ifdef CONV2_PSUM_ROUND_EN
  logic [ACC_W+1:0] bias;
  logic [ACC_W+1:0] rsum;

  // Add half an LSB of the shifted result, saturating in ACC_W+1 bits
  always_comb begin
    bias = '0;
    if (shift != 4'd0) bias[shift - 4'd1] = 1'b1;
    rsum = {{2{acc_in[ACC_W-1]}}, acc_in} + bias;
    if (rsum[ACC_W+1] != rsum[ACC_W])
      ext = rsum[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}} : {1'b0, {ACC_W{1'b1}}};
    else
      ext = rsum[ACC_W:0];
  end
`else
  // Plain truncating shift: just sign-extend
  always_comb begin
    ext = {acc_in[ACC_W-1], acc_in};
  end
`endif

  // Arithmetic shift, then ReLU and clamp to the unsigned output range
  always_comb begin
    shifted = ext >>> shift;
    if (shifted[ACC_W])
      q = '0;
    else if (|shifted[ACC_W-1:OUT_W])
      q = '1;
    else
      q = shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/conv2_psum_accum.sv
// conv2_psum_accum: accumulates the 12-lane column partial sums over a
// group of input-channel passes, then requantises the group result into
// one 96-bit output word behind a single-entry valid/ready register.
// Optional feature: CONV2_PSUM_ROUND_EN (round half up in requant).
module conv2_psum_accum
  import conv2_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  conv2_psum_accum_if.slave   bus
);

  conv2_state_e                  state;
  logic [LANES-1:0][ACC_W-1:0]   acc;
  logic [LANES-1:0][ACC_W-1:0]   acc_next;
  logic [OUT_BUS_W-1:0]          q_word;
  logic [OUT_BUS_W-1:0]          out_data_r;
  logic                          out_vld_r;
  logic                          err_r;
  logic                          psum_rdy;
  logic                          accept;
  logic                          start;
  logic                          proto_err;

  // Output register may reload in the same cycle it is drained
  assign psum_rdy  = rst_n & en & (~out_vld_r | bus.out_rdy);
  assign accept    = en & bus.psum_vld & psum_rdy;
  // A beat without first in IDLE opens the group as if it were first
  assign start     = bus.psum_first | (state == IDLE);
  assign proto_err = (bus.psum_first & (state == ACC)) |
                     (~bus.psum_first & (state == IDLE));

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [PSUM_W-1:0] p;
    logic [ACC_W:0]    sum;

    assign p   = bus.psum_in[psum_lsb(k) +: PSUM_W];
    assign sum = {acc[k][ACC_W-1], acc[k]} +
                 {{(ACC_W - PSUM_W + 1){p[PSUM_W-1]}}, p};

    // Next accumulator value: restart or saturating add
    always_comb begin
      if (start)
        acc_next[k] = {{(ACC_W - PSUM_W){p[PSUM_W-1]}}, p};
      else if (sum[ACC_W] != sum[ACC_W-1])
        acc_next[k] = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
      else
        acc_next[k] = sum[ACC_W-1:0];
    end

    conv2_requant_lane u_requant (
      .acc_in (acc_next[k]),
      .shift  (bus.shift),
      .q      (q_word[out_lsb(k) +: OUT_W])
    );
  end

  // Group FSM and accumulators advance only on accepted beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      err_r <= 1'b0;
    end else if (accept) begin
      if (proto_err) err_r <= 1'b1;
      if (bus.psum_last) begin
        state <= IDLE;
        acc   <= '0;
      end else begin
        state <= ACC;
        acc   <= acc_next;
      end
    end
  end

  // Single-entry output register; drains even while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_r  <= 1'b0;
      out_data_r <= '0;
    end else if (accept && bus.psum_last) begin
      out_vld_r  <= 1'b1;
      out_data_r <= q_word;
    end else if (out_vld_r && bus.out_rdy) begin
      out_vld_r  <= 1'b0;
      out_data_r <= '0;
    end
  end

  assign bus.psum_rdy = psum_rdy;
  assign bus.out_vld  = out_vld_r;
  assign bus.out_data = out_data_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_conv2_psum_accum.sv
// tb_conv2_psum_accum: directed self-checking bench for conv2_psum_accum.
module tb_conv2_psum_accum;
  import conv2_pkg::*;

  logic clk;
  logic rst_n;
  logic en;
  int   checks;
  int   errors;

  conv2_psum_accum_if bus ();

  conv2_psum_accum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PSUM_BUS_W-1:0] lane_put(input int k, input logic [PSUM_W-1:0] v);
    logic [PSUM_BUS_W-1:0] r;
    r = '0;
    r[(LANES-1-k)*PSUM_W +: PSUM_W] = v;
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] lane_get(input int k);
    logic [OUT_BUS_W-1:0] d;
    d = bus.out_data;
    return d[(LANES-1-k)*OUT_W +: OUT_W];
  endfunction

  // One beat presented for exactly one rising edge; outputs sampled 1 after
  task automatic beat(input logic f, input logic l, input logic [PSUM_BUS_W-1:0] d, input logic [3:0] sh);
    @(negedge clk);
    bus.psum_vld   = 1'b1;
    bus.psum_first = f;
    bus.psum_last  = l;
    bus.psum_in    = d;
    bus.shift      = sh;
    @(posedge clk);
    #1;
    bus.psum_vld   = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    bus.psum_vld = 1'b0;
    bus.psum_first = 1'b0;
    bus.psum_last = 1'b0;
    bus.psum_in = '0;
    bus.shift = '0;
    bus.out_rdy = 1'b1;
    #12;
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %0b expected 0", bus.out_vld); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", bus.err); end
    checks++; if (bus.psum_rdy !== 1'b0) begin errors++; $display("FAIL reset_psum_rdy: got %0b expected 0", bus.psum_rdy); end
    release_reset();
    #1;
    checks++; if (bus.psum_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_psum_rdy: got %0b expected 1", bus.psum_rdy); end
  endtask

  task automatic test_single_pass();
    logic [OUT_BUS_W-1:0] exp_word;
    exp_word = '0;
    exp_word[95:88] = 8'd25;
    beat(1'b1, 1'b1, lane_put(0, 20'd100), 4'd2);
    checks++; if (bus.out_vld !== 1'b1) begin errors++; $display("FAIL single_out_vld: got %0b expected 1", bus.out_vld); end
    checks++; if (bus.out_data !== exp_word) begin errors++; $display("FAIL single_out_data: got %h expected %h", bus.out_data, exp_word); end
    idle_cycle();
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL single_drain: got %0b expected 0", bus.out_vld); end
  endtask

  task automatic test_multi_pass();
    logic [OUT_W-1:0] exp_round;
`ifdef CONV2_PSUM_ROUND_EN
    exp_round = 8'd26;
`else
    exp_round = 8'd25;
`endif
    beat(1'b1, 1'b0, lane_put(5, 20'd10), 4'd0);
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL multi_mid_vld: got %0b expected 0", bus.out_vld); end
    beat(1'b0, 1'b0, lane_put(5, 20'd20), 4'd0);
    beat(1'b0, 1'b1, lane_put(5, 20'hFFFFB), 4'd0);
    checks++; if (lane_get(5) !== 8'd25) begin errors++; $display("FAIL multi_lane5: got %0d expected 25", lane_get(5)); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL multi_err: got %0b expected 0", bus.err); end
    beat(1'b1, 1'b1, lane_put(5, 20'd102), 4'd2);
    checks++; if (lane_get(5) !== exp_round) begin errors++; $display("FAIL round_lane5: got %0d expected %0d", lane_get(5), exp_round); end
  endtask

  task automatic test_relu_clamp();
    beat(1'b1, 1'b1, lane_put(3, 20'hFFFF9) | lane_put(4, 20'h7FFFF), 4'd0);
    checks++; if (lane_get(3) !== 8'd0) begin errors++; $display("FAIL relu_lane3: got %0d expected 0", lane_get(3)); end
    checks++; if (lane_get(4) !== 8'd255) begin errors++; $display("FAIL clamp_lane4: got %0d expected 255", lane_get(4)); end
  endtask

  task automatic test_acc_saturation();
    for (int i = 0; i < 17; i++)
      beat(i == 0, i == 16, {LANES{20'h7FFFF}}, 4'd15);
    checks++; if (bus.out_data !== {LANES{8'hFF}}) begin errors++; $display("FAIL sat_out_data: got %h expected all ff", bus.out_data); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL sat_err: got %0b expected 0", bus.err); end
  endtask

  task automatic test_en_low();
    @(negedge clk);
    en = 1'b0;
    bus.psum_vld = 1'b1;
    bus.psum_first = 1'b1;
    bus.psum_last = 1'b1;
    bus.psum_in = lane_put(0, 20'd9);
    bus.shift = 4'd0;
    #1;
    checks++; if (bus.psum_rdy !== 1'b0) begin errors++; $display("FAIL en_low_psum_rdy: got %0b expected 0", bus.psum_rdy); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL en_low_drain: got %0b expected 0", bus.out_vld); end
    bus.psum_vld = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_backpressure();
    bus.out_rdy = 1'b0;
    beat(1'b1, 1'b1, lane_put(0, 20'd40), 4'd0);
    checks++; if (lane_get(0) !== 8'd40) begin errors++; $display("FAIL bp_first_word: got %0d expected 40", lane_get(0)); end
    @(negedge clk);
    bus.psum_vld = 1'b1;
    bus.psum_first = 1'b1;
    bus.psum_last = 1'b1;
    bus.psum_in = lane_put(0, 20'd60);
    #1;
    checks++; if (bus.psum_rdy !== 1'b0) begin errors++; $display("FAIL bp_psum_rdy: got %0b expected 0", bus.psum_rdy); end
    @(posedge clk);
    #1;
    checks++; if (lane_get(0) !== 8'd40) begin errors++; $display("FAIL bp_hold_data: got %0d expected 40", lane_get(0)); end
    checks++; if (bus.out_vld !== 1'b1) begin errors++; $display("FAIL bp_hold_vld: got %0b expected 1", bus.out_vld); end
    @(negedge clk);
    bus.out_rdy = 1'b1;
    #1;
    checks++; if (bus.psum_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy: got %0b expected 1", bus.psum_rdy); end
    @(posedge clk);
    #1;
    bus.psum_vld = 1'b0;
    checks++; if (bus.out_vld !== 1'b1) begin errors++; $display("FAIL bp_reload_vld: got %0b expected 1", bus.out_vld); end
    checks++; if (lane_get(0) !== 8'd60) begin errors++; $display("FAIL bp_reload_data: got %0d expected 60", lane_get(0)); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) begin
      beat(1'b1, 1'b1, lane_put(0, 20'(i * 3)), 4'd0);
      checks++; if (bus.out_vld !== 1'b1 || lane_get(0) !== 8'(i * 3)) begin
        errors++; $display("FAIL b2b_word%0d: got vld=%0b lane0=%0d expected vld=1 lane0=%0d", i, bus.out_vld, lane_get(0), i * 3);
      end
    end
    idle_cycle();
  endtask

  task automatic test_protocol_err();
    beat(1'b0, 1'b0, lane_put(0, 20'd30), 4'd0);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_no_first: got %0b expected 1", bus.err); end
    beat(1'b0, 1'b1, lane_put(0, 20'd5), 4'd0);
    checks++; if (lane_get(0) !== 8'd35) begin errors++; $display("FAIL err_as_first_sum: got %0d expected 35", lane_get(0)); end
    pulse_reset();
    release_reset();
    beat(1'b1, 1'b0, lane_put(0, 20'd50), 4'd0);
    beat(1'b1, 1'b1, lane_put(0, 20'd3), 4'd0);
    checks++; if (lane_get(0) !== 8'd3) begin errors++; $display("FAIL restart_data: got %0d expected 3", lane_get(0)); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL restart_err: got %0b expected 1", bus.err); end
  endtask

  task automatic test_mid_group_reset();
    bus.out_rdy = 1'b0;
    beat(1'b1, 1'b1, lane_put(2, 20'd77), 4'd0);
    beat(1'b1, 1'b0, lane_put(0, 20'd11), 4'd0);
    pulse_reset();
    checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL midrst_out_vld: got %0b expected 0", bus.out_vld); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL midrst_out_data: got %h expected 0", bus.out_data); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %0b expected 0", bus.err); end
    bus.out_rdy = 1'b1;
    release_reset();
    beat(1'b1, 1'b1, lane_put(0, 20'd7), 4'd0);
    checks++; if (lane_get(0) !== 8'd7) begin errors++; $display("FAIL after_rst_data: got %0d expected 7", lane_get(0)); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL after_rst_err: got %0b expected 0", bus.err); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_relu_clamp();
    test_acc_saturation();
    test_en_low();
    test_backpressure();
    test_back_to_back();
    test_protocol_err();
    test_mid_group_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2_psum_accum.md
# conv2_psum_accum

Downstream stage of the conv-layer-2 twelve-PE column. It consumes the 240-bit column partial-sum bus (12 lanes × 20-bit) once per input-channel pass and accumulates the lanes over a configurable number of passes. On the last pass it applies rounding, arithmetic shift, ReLU and 8-bit saturation, then presents a 96-bit output-feature-map word to the next layer's ifmap buffer over a valid/ready handshake.

## Interface
- LANES, 12, number of PE lanes
- PSUM_W, 20, partial-sum width per lane, signed two's complement
- ACC_W, 24, accumulator width per lane, signed
- OUT_W, 8, output pixel width, unsigned
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  global enable; low freezes all state
- psum_vld  in  1  psum_in beat valid
- psum_first  in  1  first pass of a group; qualifies the beat
- psum_last  in  1  last pass of a group; qualifies the beat
- psum_in  in  240  lane k at [239-20k -: 20]
- psum_rdy  out  1  beat accepted when en & psum_vld & psum_rdy
- shift  in  4  right-shift amount; sampled on the last beat
- out_vld  out  1  out_data valid
- out_rdy  in  1  downstream ready
- out_data  out  96  lane k at [95-8k -: 8]
- err  out  1  sticky protocol-error flag

## Operation
- FSM: IDLE (no group open), ACC (group open).
- Accept = en & psum_vld & psum_rdy. psum_rdy = en & (!out_vld | out_rdy).
- Accepted beat with psum_first: acc[k] = sext(psum[k]). The previous contents are discarded. The FSM moves to ACC.
- Accepted beat without psum_first, in ACC: acc[k] = sat_ACC(acc[k] + sext(psum[k])). The sum clamps to [-2^23, 2^23-1].
- Accepted beat without psum_first, in IDLE: the beat is treated as first and err is set.
- psum_first accepted while in ACC: the group restarts and err is set.
- Accepted beat with psum_last: out_data[k] = requant(acc_next[k], shift) and out_vld is set. acc is cleared and the FSM returns to IDLE. first and last together form a single-pass group.
- requant: x = acc_next >>> shift (arithmetic). If x < 0, the result is 0. If x > 255, the result is 255. Otherwise the result is x[7:0].
- Output register is one entry. It clears on out_vld & out_rdy, unless a new last beat is accepted in the same cycle, in which case it reloads and out_vld stays 1.
- When en is low: no accept, psum_rdy = 0, and out_vld/out_data hold. A downstream handshake still completes if out_rdy is high.

## Timing
- Reset values: out_vld = 0, out_data = 0, err = 0, acc = 0, FSM = IDLE. psum_rdy reads 0 while rst_n is low.
- Latency: out_vld rises in the cycle after the accepted last beat.
- Throughput: one beat per cycle. A single-pass group every cycle sustains full rate when out_rdy is held at 1.
- Backpressure: while out_vld = 1 and out_rdy = 0, psum_rdy = 0 and the accumulators hold.
- Reset asserted mid-group clears everything. The partial group is lost and err is not set.

## Configuration
- CONV2_PSUM_ROUND_EN defined: requant adds 2^(shift-1) before the shift when shift ≠ 0 (round half up). The add is done with saturation in ACC_W+1 bits.
- CONV2_PSUM_ROUND_EN undefined: plain truncating arithmetic shift.

## Structure
- Package conv2_pkg holds LANES, PSUM_W, ACC_W, OUT_W, the FSM state enum, and the lane-slice index helpers shared with the PE column.
- Sub-module conv2_requant_lane is a combinational block, one instance per lane. It implements rounding, shift, ReLU and clamp. It is generated LANES times.

## Test plan
- Single-pass group, lane 0 = 100, shift = 2, all other lanes 0, out_rdy = 1 -> one cycle later out_vld = 1 and out_data[95:88] = 25.
- Three passes, lane 5 = 10, 20, -5, shift = 0 -> out_data lane 5 = 25. Without the macro, lane 5 = 102 with shift = 2 -> 25; with CONV2_PSUM_ROUND_EN -> 26.
- Lane 3 single pass = -7 -> out_data lane 3 = 0. Lane 4 = 20'h7FFFF with shift = 0 -> 255.
- Seventeen passes of 20'h7FFFF on every lane, shift = 15 -> accumulator saturates at 8388607 and output = 255 on all lanes. err stays 0.
- Hold out_rdy = 0 after a result, then offer a new last beat -> psum_rdy = 0 and out_data is unchanged. Release out_rdy -> handshake occurs, the beat is accepted, and the new word appears one cycle later.
- Beat without first in IDLE -> err = 1 and the beat is accumulated as first. Assert rst_n = 0 mid-group -> all outputs return to 0.
